// File: rtl/branch_cmp_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_cmp_serial : MSB-first serial branch comparator (BR_LESS/EQUAL)    |
// | Option macro: BRC_EARLY_EXIT_EN (stop at first differing bit)             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+

module comparator_1bit (
  input  logic a,
  input  logic b,
  output logic greater,
  output logic equal,
  output logic less
);
  assign greater = a & ~b;
  assign equal   = ~(a ^ b);
  assign less    = ~a & b;
endmodule

module branch_cmp_serial #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_br_un,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_br_less,
  output logic             o_br_equal
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] C_IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_br_un;
  logic [IW-1:0]    r_idx;

  logic w_bit_a;
  logic w_bit_b;
  logic w_gt_1;
  logic w_eq_1;
  logic w_lt_1;
  logic w_bit_less;

  assign w_bit_a = r_op_a[r_idx];
  assign w_bit_b = r_op_b[r_idx];

  comparator_1bit u_cmp (
    .a       (w_bit_a),
    .b       (w_bit_b),
    .greater (w_gt_1),
    .equal   (w_eq_1),
    .less    (w_lt_1)
  );

  // A signed sign-bit mismatch flips the sense: the side holding the 1 is negative.
  assign w_bit_less = (!r_br_un && (r_idx == C_IDX_MSB)) ? w_gt_1 : w_lt_1;

`ifndef BRC_EARLY_EXIT_EN
  logic r_found;
  logic r_found_less;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_br_un      <= 1'b0;
      r_idx        <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_br_less    <= 1'b0;
      o_br_equal   <= 1'b0;
`ifndef BRC_EARLY_EXIT_EN
      r_found      <= 1'b0;
      r_found_less <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_op_a     <= i_rs1_data;
            r_op_b     <= i_rs2_data;
            r_br_un    <= i_br_un;
            r_idx      <= C_IDX_MSB;
            o_busy     <= 1'b1;
            o_br_less  <= 1'b0;
            o_br_equal <= 1'b0;
`ifndef BRC_EARLY_EXIT_EN
            r_found      <= 1'b0;
            r_found_less <= 1'b0;
`endif
            r_state    <= S_CMP;
          end
        end

        S_CMP: begin
`ifdef BRC_EARLY_EXIT_EN
          if (!w_eq_1) begin
            o_br_less  <= w_bit_less;
            o_br_equal <= 1'b0;
            o_done     <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_idx == '0) begin
            o_br_less  <= 1'b0;
            o_br_equal <= 1'b1;
            o_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
`else
          // Only the most significant differing bit is allowed to decide.
          if (!r_found && !w_eq_1) begin
            r_found      <= 1'b1;
            r_found_less <= w_bit_less;
          end
          if (r_idx == '0) begin
            if (r_found) begin
              o_br_less  <= r_found_less;
              o_br_equal <= 1'b0;
            end else if (!w_eq_1) begin
              o_br_less  <= w_bit_less;
              o_br_equal <= 1'b0;
            end else begin
              o_br_less  <= 1'b0;
              o_br_equal <= 1'b1;
            end
            o_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
`endif
        end

        S_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_cmp_serial.sv
`default_nettype none
// Self-checking bench for branch_cmp_serial: scoreboard of expected flags/latency.
// Latency expectations follow BRC_EARLY_EXIT_EN when defined.
module tb_branch_cmp_serial;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic         br_un;
  logic         busy;
  logic         done;
  logic         br_less;
  logic         br_equal;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic less;
    logic equal;
    int   lat;
  } exp_t;
  exp_t sb[$];

  logic last_less  = 1'b0;
  logic last_equal = 1'b0;

  branch_cmp_serial #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_br_un    (br_un),
    .o_busy     (busy),
    .o_done     (done),
    .o_br_less  (br_less),
    .o_br_equal (br_equal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    lat = W;
`ifdef BRC_EARLY_EXIT_EN
    for (int i = 0; i < W; i++)
      if (a[i] != b[i]) lat = W - i;
`endif
    return lat;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic un);
    exp_t e;
    rs1   = a;
    rs2   = b;
    br_un = un;
    start = 1'b1;
    e.less  = un ? (a < b) : ($signed(a) < $signed(b));
    e.equal = (a == b);
    e.lat   = exp_lat(a, b);
    sb.push_back(e);
  endtask

  // Consumes the accepting edge, then waits for o_done; returns just after it.
  task automatic wait_result(input string name);
    exp_t e;
    int   n;
    bit   seen;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_rise got=%b want=1", name, busy);
    end
    vectors++;
    if ({br_less, br_equal} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s flags_clear got=%b%b want=00", name, br_less, br_equal);
    end
    seen = 0;
    n = 0;
    for (int c = 1; c <= W + 4; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1;
        n = c;
        break;
      end
    end
    e = sb.pop_front();
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s done_timeout got=none want=cycle %0d", name, e.lat);
    end else begin
      if (n != e.lat) begin
        miscompares++;
        $display("FAIL %s latency got=%0d want=%0d", name, n, e.lat);
      end
      vectors++;
      if (br_less !== e.less || br_equal !== e.equal) begin
        miscompares++;
        $display("FAIL %s flags got less=%b eq=%b want less=%b eq=%b",
                 name, br_less, br_equal, e.less, e.equal);
      end
    end
    last_less  = e.less;
    last_equal = e.equal;
  endtask

  task automatic check_idle(input string name);
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle got done=%b busy=%b want 0 0", name, done, busy);
    end
    vectors++;
    if (br_less !== last_less || br_equal !== last_equal) begin
      miscompares++;
      $display("FAIL %s hold got less=%b eq=%b want less=%b eq=%b",
               name, br_less, br_equal, last_less, last_equal);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; rs1 = '0; rs2 = '0; br_un = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, br_less, br_equal} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async got=%b want=0000", {busy, done, br_less, br_equal});
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, br_less, br_equal} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_held got=%b want=0000", {busy, done, br_less, br_equal});
    end
    @(negedge clk) rst_n = 1'b1;
    last_less = 1'b0; last_equal = 1'b0;
  endtask

  task automatic test_unsigned_msb();
    @(negedge clk); issue(32'h8000_0000, 32'h0000_0001, 1'b1);
    wait_result("unsigned_msb");
    check_idle("unsigned_msb");
  endtask

  task automatic test_signed_msb();
    @(negedge clk); issue(32'h8000_0000, 32'h0000_0001, 1'b0);
    wait_result("signed_msb");
    check_idle("signed_msb");
  endtask

  task automatic test_equal();
    @(negedge clk); issue(32'h1234_5678, 32'h1234_5678, 1'b1);
    wait_result("equal");
    check_idle("equal");
  endtask

  task automatic test_lsb();
    @(negedge clk); issue(32'd4, 32'd5, 1'b1);
    wait_result("lsb_only");
    check_idle("lsb_only");
    @(negedge clk); issue(32'hFFFF_FFFF, 32'h0, 1'b0);
    wait_result("signed_neg1");
    check_idle("signed_neg1");
  endtask

  task automatic test_back_to_back();
    @(negedge clk); issue(32'h0000_00F0, 32'h0000_0F00, 1'b1);
    wait_result("b2b_first");
    issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    check_idle("b2b_gap");
    wait_result("b2b_second");
    check_idle("b2b_second");
  endtask

  task automatic test_busy_start();
    exp_t e;
    int   ndone;
    int   seen_n;
    logic got_less;
    logic got_eq;
    @(negedge clk); issue(32'd5, 32'd4, 1'b1);
    e = sb.pop_front();
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; seen_n = 0; got_less = 1'bx; got_eq = 1'bx;
    for (int n = 1; n <= W + 6; n++) begin
      if (n == 3) begin
        rs1 = 32'h8000_0000; rs2 = 32'h1; br_un = 1'b0; start = 1'b1;
      end
      if (n == 5) start = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        if (seen_n == 0) begin
          seen_n = n; got_less = br_less; got_eq = br_equal;
        end
      end
    end
    vectors++;
    if (ndone != 1) begin
      miscompares++;
      $display("FAIL busy_start done_pulses got=%0d want=1", ndone);
    end
    vectors++;
    if (seen_n != e.lat) begin
      miscompares++;
      $display("FAIL busy_start latency got=%0d want=%0d", seen_n, e.lat);
    end
    vectors++;
    if (got_less !== e.less || got_eq !== e.equal) begin
      miscompares++;
      $display("FAIL busy_start flags got less=%b eq=%b want less=%b eq=%b",
               got_less, got_eq, e.less, e.equal);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start idle_after got busy=%b want=0", busy);
    end
    last_less = e.less; last_equal = e.equal;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); issue(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
    void'(sb.pop_front());
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, br_less, br_equal} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid got=%b want=0000", {busy, done, br_less, br_equal});
    end
    #10 rst_n = 1'b1;
    last_less = 1'b0; last_equal = 1'b0;
    @(negedge clk); issue(32'h0000_1000, 32'h0000_0FFF, 1'b0);
    wait_result("after_reset");
    check_idle("after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? (a ^ (32'h1 << $urandom_range(0, W - 1))) : $urandom;
      @(negedge clk); issue(a, b, 1'($urandom_range(0, 1)));
      wait_result("random");
      check_idle("random");
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_msb();
    test_signed_msb();
    test_equal();
    test_lsb();
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
